// File: rtl/cla_divider_16bit.sv
// Purpose : 16-bit unsigned restoring divider, one quotient bit per cycle via a 17-bit CLA trial subtract.
// Latency : 16 cycles start-to-done for a nonzero divisor, 1 cycle for a zero divisor; one op in flight.
// Backpr. : none; start is only honoured in IDLE/DONE and is silently ignored while busy.
//
// Ports:
//   clk, rst              - single clock, asynchronous active-high reset
//   start                 - request, accepted in IDLE or DONE
//   dividend, divisor     - operands, captured on the accepting edge
//   busy                  - high while iterating
//   done                  - one-cycle pulse when results become valid
//   quotient, remainder   - results, held until the next completed operation
//   div_by_zero           - set with results when the captured divisor was 0
module cla_divider_16bit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [15:0] q_reg;      // dividend shifting out, quotient bits shifting in
    logic [15:0] d_reg;      // captured divisor
    // The held partial remainder is always < divisor, so its bit 16 is
    // always zero between iterations; only the shifted trial operand needs
    // the full 17 bits.
    logic [15:0] r_reg;
    logic [3:0]  cnt;

    logic        accept;
    logic        last_iter;
    logic        busy_nxt;
    logic        done_nxt;

    // ------------------------------------------------------------------
    // 17-bit trial subtraction: R_shifted + ~{0,D} + 1 through a two-level
    // carry-lookahead adder (4 groups of 4 bits plus a top bit).
    // ------------------------------------------------------------------
    logic [16:0] trial_a;
    logic [16:0] trial_b;
    logic [16:0] prop;
    logic [16:0] gen;
    logic [16:0] carry;      // carry into each bit position
    logic [3:0]  grp_g;
    logic [3:0]  grp_p;
    logic [4:0]  grp_c;      // carry into each group, grp_c[4] into bit 16
    logic [15:0] trial_sum;
    logic        trial_cout; // 1 = no borrow, R_shifted >= D
    logic [15:0] r_next;
    logic [15:0] q_next;

    // Carries into bits 1..3 of a 4-bit group, fully expanded.
    function automatic logic [2:0] cla4_inner(input logic [3:0] p,
                                              input logic [3:0] g,
                                              input logic       c0);
        logic c1, c2, c3;
        c1 = g[0] | (p[0] & c0);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                  | (p[2] & p[1] & p[0] & c0);
        return {c3, c2, c1};
    endfunction

    function automatic logic grp_gen(input logic [3:0] p, input logic [3:0] g);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                    | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    always_comb begin
        trial_a = {r_reg, q_reg[15]};
        trial_b = ~{1'b0, d_reg};
        prop    = trial_a ^ trial_b;
        gen     = trial_a & trial_b;

        grp_g = '0;
        grp_p = '0;
        for (int k = 0; k < 4; k++) begin
            grp_g[k] = grp_gen(prop[4*k +: 4], gen[4*k +: 4]);
            grp_p[k] = &prop[4*k +: 4];
        end

        // Second-level lookahead; carry-in is 1 for the two's complement.
        grp_c[0] = 1'b1;
        grp_c[1] = grp_g[0] | (grp_p[0] & grp_c[0]);
        grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0])
                            | (grp_p[1] & grp_p[0] & grp_c[0]);
        grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1])
                            | (grp_p[2] & grp_p[1] & grp_g[0])
                            | (grp_p[2] & grp_p[1] & grp_p[0] & grp_c[0]);
        grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2])
                            | (grp_p[3] & grp_p[2] & grp_g[1])
                            | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                            | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & grp_c[0]);

        carry = '0;
        for (int k = 0; k < 4; k++) begin
            carry[4*k]         = grp_c[k];
            carry[4*k+1 +: 3]  = cla4_inner(prop[4*k +: 4], gen[4*k +: 4], grp_c[k]);
        end
        carry[16] = grp_c[4];

        // Bit 16 of the sum is zero whenever there is no borrow, so only
        // the low 16 bits are formed; bit 16 still feeds the carry-out.
        trial_sum  = prop[15:0] ^ carry[15:0];
        trial_cout = gen[16] | (prop[16] & carry[16]);

        r_next = trial_cout ? trial_sum : trial_a[15:0];
        q_next = {q_reg[14:0], trial_cout};
    end

    assign accept    = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign last_iter = (state == ST_RUN) && (cnt == 4'd15);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_nxt = (divisor == 16'd0) ? ST_DONE : ST_RUN;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_iter) begin
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode, registered below so busy/done are glitch-free
    // ------------------------------------------------------------------
    always_comb begin
        busy_nxt = 1'b0;
        done_nxt = 1'b0;
        case (state_nxt)
            ST_RUN:  busy_nxt = 1'b1;
            ST_DONE: done_nxt = 1'b1;
            default: begin
                busy_nxt = 1'b0;
                done_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_nxt;
            done <= done_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: operand capture, iteration, result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            q_reg <= dividend;
            d_reg <= divisor;
            r_reg <= '0;
            cnt   <= '0;
            if (divisor == 16'd0) begin
                quotient    <= 16'hFFFF;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else begin
                div_by_zero <= 1'b0;
            end
        end else if (state == ST_RUN) begin
            q_reg <= q_next;
            r_reg <= r_next;
            cnt   <= cnt + 4'd1;
            if (last_iter) begin
                quotient  <= q_next;
                remainder <= r_next;
            end
        end
    end

endmodule

// File: tb/tb_cla_divider_16bit.sv
// Purpose : self-checking bench for cla_divider_16bit against an arithmetic reference model.
// Latency : model predicts done 16 edges after a nonzero-divisor accept, 1 edge for zero.
// Backpr. : n/a; bench drives start/operands on the falling edge, checks on the falling edge.
module tb_cla_divider_16bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    cla_divider_16bit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: tracks operations by edge number and uses plain
    // / and % for results.
    // ------------------------------------------------------------------
    int          edge_no;
    int          acc_edge;
    logic        acc_nz;
    logic [15:0] acc_a, acc_b;
    logic [15:0] pend_q, pend_r;
    logic        m_busy, m_done, m_dbz;
    logic [15:0] m_q, m_r;
    int          e_nx;
    logic        m_in_run;

    assign e_nx     = edge_no + 1;
    assign m_in_run = acc_nz && (e_nx > acc_edge) && (e_nx <= acc_edge + 16);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_no  <= 0;
            acc_edge <= 0;
            acc_nz   <= 1'b0;
            acc_a    <= '0;
            acc_b    <= '0;
            pend_q   <= '0;
            pend_r   <= '0;
            m_busy   <= 1'b0;
            m_done   <= 1'b0;
            m_dbz    <= 1'b0;
            m_q      <= '0;
            m_r      <= '0;
        end else begin
            edge_no <= e_nx;
            if (start && !m_in_run) begin
                acc_edge <= e_nx;
                acc_nz   <= (divisor != 16'd0);
                acc_a    <= dividend;
                acc_b    <= divisor;
                if (divisor == 16'd0) begin
                    m_q    <= 16'hFFFF;
                    m_r    <= dividend;
                    m_dbz  <= 1'b1;
                    m_done <= 1'b1;
                    m_busy <= 1'b0;
                end else begin
                    pend_q <= dividend / divisor;
                    pend_r <= dividend % divisor;
                    m_dbz  <= 1'b0;
                    m_done <= 1'b0;
                    m_busy <= 1'b1;
                end
            end else if (acc_nz && e_nx == acc_edge + 16) begin
                m_q    <= pend_q;
                m_r    <= pend_r;
                m_done <= 1'b1;
                m_busy <= 1'b0;
            end else begin
                m_done <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle compare against the model
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            check("busy", {31'd0, busy}, {31'd0, m_busy});
            check("done", {31'd0, done}, {31'd0, m_done});
            check("quotient", {16'd0, quotient}, {16'd0, m_q});
            check("remainder", {16'd0, remainder}, {16'd0, m_r});
            check("div_by_zero", {31'd0, div_by_zero}, {31'd0, m_dbz});
            if (done) begin
                n_done++;
                if (!div_by_zero) begin
                    check("invariant", {16'd0, quotient} * {16'd0, acc_b} + {16'd0, remainder},
                          {16'd0, acc_a});
                    check("rem_lt_div", {31'd0, (remainder < acc_b)}, 32'd1);
                end
            end
        end
    end

    // One directed operation: raise start for one cycle, wait for done,
    // then compare against hand-computed values.
    task automatic do_div(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] eq, input logic [15:0] er,
                          input logic edbz, input int elat, input int ebusy,
                          input string tag);
        int n;
        int nb;
        n  = 0;
        nb = 0;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        do begin
            @(negedge clk);
            start = 1'b0;
            n++;
            if (busy) nb++;
        end while (!done && n < 40);
        check({tag, "_latency"}, n, elat);
        check({tag, "_busy_cycles"}, nb, ebusy);
        check({tag, "_quotient"}, {16'd0, quotient}, {16'd0, eq});
        check({tag, "_remainder"}, {16'd0, remainder}, {16'd0, er});
        check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, edbz});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_quotient"}, {16'd0, quotient}, 32'd0);
        check({tag, "_remainder"}, {16'd0, remainder}, 32'd0);
        check({tag, "_dbz"}, {31'd0, div_by_zero}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int n;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        check_all_zero("in_reset");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("after_reset");

        // Directed vectors
        do_div(16'd100,   16'd7,    16'd14,   16'd2,    1'b0, 17, 16, "basic");
        do_div(16'hFFFF,  16'd1,    16'hFFFF, 16'd0,    1'b0, 17, 16, "max_by_1");
        do_div(16'hFFFF,  16'hFFFF, 16'd1,    16'd0,    1'b0, 17, 16, "max_by_max");
        do_div(16'd3,     16'd10,   16'd0,    16'd3,    1'b0, 17, 16, "small_by_big");
        do_div(16'd0,     16'd5,    16'd0,    16'd0,    1'b0, 17, 16, "zero_num");
        do_div(16'h8000,  16'h00FF, 16'h0080, 16'h0080, 1'b0, 17, 16, "msb_num");
        do_div(16'h1234,  16'd0,    16'hFFFF, 16'h1234, 1'b1, 1,  0,  "div0");
        do_div(16'd9,     16'd3,    16'd3,    16'd0,    1'b0, 17, 16, "after_div0");
        do_div(16'd0,     16'd0,    16'hFFFF, 16'd0,    1'b1, 1,  0,  "zero_by_zero");
        repeat (3) @(negedge clk);

        // Start during RUN is ignored
        d0 = n_done;
        dividend = 16'd50;
        divisor  = 16'd5;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        dividend = 16'd99;
        divisor  = 16'd9;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (25) @(negedge clk);
        check("ignored_start_done_count", n_done - d0, 1);
        check("ignored_start_quotient", {16'd0, quotient}, 32'd10);
        check("ignored_start_remainder", {16'd0, remainder}, 32'd0);

        // Reset during RUN
        d0 = n_done;
        dividend = 16'd1000;
        divisor  = 16'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("mid_run_reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("no_done_after_reset", n_done - d0, 0);
        check_all_zero("idle_after_reset");
        do_div(16'd2000, 16'd7, 16'd285, 16'd5, 1'b0, 17, 16, "post_reset");

        // Back-to-back regression with start held high
        divisor  = 16'($urandom_range(1, 16'hFFFF));
        dividend = 16'($urandom);
        start    = 1'b1;
        for (int i = 0; i < 200; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
                dividend = 16'($urandom);
                divisor  = (i % 4 == 0) ? 16'($urandom_range(1, 255))
                                        : 16'($urandom_range(1, 16'hFFFF));
            end while (!done && n < 40);
            check("done_period", n, 17);
        end
        start = 1'b0;
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
